// File: rtl/axis_stall_driver_if.sv
// AXI-Stream pair between axis_stall_driver (master side) and the kernel under test (slave side).
// Handshake: a beat transfers on a rising clock edge where TVALID and TREADY are both high;
// once TVALID is raised, TDATA/TLAST/TVALID stay stable until that transfer; TREADY may change freely.
interface axis_stall_driver_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] in_r_TDATA;
   logic              in_r_TVALID;
   logic              in_r_TLAST;
   logic              in_r_TREADY;
   logic [DATA_W-1:0] out_r_TDATA;
   logic              out_r_TVALID;
   logic              out_r_TREADY;

   modport master (
      output in_r_TDATA,
      output in_r_TVALID,
      output in_r_TLAST,
      input  in_r_TREADY,
      input  out_r_TDATA,
      input  out_r_TVALID,
      output out_r_TREADY
   );

   modport slave (
      input  in_r_TDATA,
      input  in_r_TVALID,
      input  in_r_TLAST,
      output in_r_TREADY,
      output out_r_TDATA,
      output out_r_TVALID,
      input  out_r_TREADY
   );
endinterface

// File: rtl/axis_stall_driver.sv
// Throttled AXI-Stream source/sink around a kernel under test, with a no-progress watchdog.
// Optional macro STALL_TRACE_EN adds the 32-bit RUN cycle counter behind stall_cycle plus a hang trace line.
module axis_stall_driver #(
   parameter int          DATA_W    = 16,
   parameter int          IN_WORDS  = 16,
   parameter int          OUT_WORDS = 1,
   parameter int          TIMEOUT   = 1024,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                ap_clk,
   input  logic                ap_rst,
   input  logic                start,
   input  logic [3:0]          src_stall,
   input  logic [3:0]          snk_stall,
   input  logic [DATA_W-1:0]   data_base,
   axis_stall_driver_if.master axis,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   last_out,
   output logic                stall_detect,
   output logic                src_blk,
   output logic                snk_blk,
   output logic [31:0]         stall_cycle,
   output logic [1:0]          fsm_state
);

   localparam int SENT_W = $clog2(IN_WORDS + 1);
   localparam int RCVD_W = $clog2(OUT_WORDS + 1);
   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   localparam logic [SENT_W-1:0] IN_END    = SENT_W'(IN_WORDS);
   localparam logic [SENT_W-1:0] IN_LAST   = SENT_W'(IN_WORDS - 1);
   localparam logic [RCVD_W-1:0] OUT_END   = RCVD_W'(OUT_WORDS);
   localparam logic [WDOG_W-1:0] WDOG_TERM = WDOG_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_HUNG = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [15:0]       lfsr_q, lfsr_d;
   logic [SENT_W-1:0] sent_q, sent_d, sent_nx;
   logic [RCVD_W-1:0] rcvd_q, rcvd_d, rcvd_nx;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;
   logic [DATA_W-1:0] tdata_q, tdata_d;
   logic              tready_q, tready_d;
   logic [DATA_W-1:0] last_out_q, last_out_d;
   logic              stall_q, stall_d;

   logic hs_in, hs_out, src_ok, snk_ok;
   logic run_complete, fire, more_beats, next_valid;

   assign hs_in   = tvalid_q & axis.in_r_TREADY;
   assign hs_out  = tready_q & axis.out_r_TVALID;
   assign src_ok  = lfsr_q[3:0] >= src_stall;
   assign snk_ok  = lfsr_q[7:4] >= snk_stall;
   assign sent_nx = sent_q + SENT_W'(hs_in);
   assign rcvd_nx = rcvd_q + RCVD_W'(hs_out);

   assign more_beats   = sent_nx != IN_END;
   assign next_valid   = more_beats & src_ok;
   assign run_complete = (state_q == S_RUN) & (sent_nx == IN_END) & (rcvd_nx == OUT_END);
   // A handshake in the terminal-count cycle takes precedence over declaring a hang.
   assign fire = (state_q == S_RUN) & ~run_complete & ~hs_in & ~hs_out & (wdog_q == WDOG_TERM);

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q    <= S_IDLE;
         lfsr_q     <= LFSR_SEED;
         sent_q     <= '0;
         rcvd_q     <= '0;
         wdog_q     <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tdata_q    <= '0;
         tready_q   <= 1'b0;
         last_out_q <= '0;
         stall_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         sent_q     <= sent_d;
         rcvd_q     <= rcvd_d;
         wdog_q     <= wdog_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         tdata_q    <= tdata_d;
         tready_q   <= tready_d;
         last_out_q <= last_out_d;
         stall_q    <= stall_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      sent_d     = sent_q;
      rcvd_d     = rcvd_q;
      wdog_d     = '0;
      tvalid_d   = tvalid_q;
      tlast_d    = tlast_q;
      tdata_d    = tdata_q;
      tready_d   = 1'b0;
      last_out_d = last_out_q;
      stall_d    = stall_q;

      case (state_q)
         S_IDLE: begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            if (start) begin
               state_d = S_RUN;
               sent_d  = '0;
               rcvd_d  = '0;
            end
         end

         S_RUN: begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            sent_d = sent_nx;
            rcvd_d = rcvd_nx;
            if (hs_out) begin
               last_out_d = axis.out_r_TDATA;
            end
            // New beat only when the bus is idle or the current beat transfers; otherwise hold it.
            if (!tvalid_q || hs_in) begin
               tvalid_d = next_valid;
               tdata_d  = data_base + DATA_W'(sent_nx);
               tlast_d  = next_valid & (sent_nx == IN_LAST);
            end
            tready_d = (rcvd_nx != OUT_END) & snk_ok;

            if (run_complete) begin
               state_d = S_DONE;
            end else if (fire) begin
               state_d  = S_HUNG;
               stall_d  = 1'b1;
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               tready_d = 1'b0;
            end else if (!(hs_in || hs_out)) begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         S_HUNG: begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef STALL_TRACE_EN
   logic [31:0] cyc_q;
   logic [31:0] stall_cycle_q;

   // stall_cycle counts RUN cycles up to and including the cycle that declared the hang.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         cyc_q         <= '0;
         stall_cycle_q <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            cyc_q <= '0;
         end else if (state_q == S_RUN) begin
            cyc_q <= cyc_q + 32'd1;
         end
         if (fire) begin
            stall_cycle_q <= cyc_q + 32'd1;
         end
      end
   end

   assign stall_cycle = stall_cycle_q;

`ifndef SYNTHESIS
   always_ff @(posedge ap_clk) begin
      if (!ap_rst && fire) begin
         $display("axis_stall_driver: hang declared at run cycle %0d, sent %0d, rcvd %0d",
                  cyc_q + 32'd1, sent_q, rcvd_q);
      end
   end
`endif
`else
   assign stall_cycle = '0;
`endif

   assign axis.in_r_TDATA  = tdata_q;
   assign axis.in_r_TVALID = tvalid_q;
   assign axis.in_r_TLAST  = tlast_q;
   assign axis.out_r_TREADY = tready_q;

   assign busy         = (state_q == S_RUN);
   assign done         = (state_q == S_DONE);
   assign last_out     = last_out_q;
   assign stall_detect = stall_q;
   assign src_blk      = tvalid_q & ~axis.in_r_TREADY;
   assign snk_blk      = tready_q & ~axis.out_r_TVALID;
   assign fsm_state    = state_q;

endmodule

// File: tb/tb_axis_stall_driver.sv
// Directed bench for axis_stall_driver: kernel model on the interface, scoreboard on in_r beats.
module tb_axis_stall_driver;
   localparam int DATA_W = 16;

   logic              ap_clk = 1'b0;
   logic              ap_rst;
   logic              start;
   logic [3:0]        src_stall;
   logic [3:0]        snk_stall;
   logic [DATA_W-1:0] data_base;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] last_out;
   logic              stall_detect;
   logic              src_blk;
   logic              snk_blk;
   logic [31:0]       stall_cycle;
   logic [1:0]        fsm_state;

   int n_vec = 0;
   int n_err = 0;
   logic [DATA_W-1:0] exp_q[$];

   axis_stall_driver_if #(.DATA_W(DATA_W)) k_if ();

   axis_stall_driver #(.DATA_W(DATA_W)) dut (
      .ap_clk       (ap_clk),
      .ap_rst       (ap_rst),
      .start        (start),
      .src_stall    (src_stall),
      .snk_stall    (snk_stall),
      .data_base    (data_base),
      .axis         (k_if),
      .busy         (busy),
      .done         (done),
      .last_out     (last_out),
      .stall_detect (stall_detect),
      .src_blk      (src_blk),
      .snk_blk      (snk_blk),
      .stall_cycle  (stall_cycle),
      .fsm_state    (fsm_state)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_zero();
      check("z_busy", busy, 0);
      check("z_done", done, 0);
      check("z_last_out", last_out, 0);
      check("z_stall_detect", stall_detect, 0);
      check("z_stall_cycle", stall_cycle, 0);
      check("z_tvalid", k_if.in_r_TVALID, 0);
      check("z_tlast", k_if.in_r_TLAST, 0);
      check("z_tdata", k_if.in_r_TDATA, 0);
      check("z_tready", k_if.out_r_TREADY, 0);
      check("z_src_blk", src_blk, 0);
      check("z_snk_blk", snk_blk, 0);
      check("z_state", fsm_state, 0);
   endtask

   // Reset asserted for one edge; outputs are sampled while reset is still high.
   task automatic do_reset();
      @(negedge ap_clk);
      ap_rst = 1'b1;
      start = 1'b0;
      k_if.in_r_TREADY = 1'b0;
      k_if.out_r_TVALID = 1'b0;
      @(negedge ap_clk);
      #1;
      check_zero();
      ap_rst = 1'b0;
   endtask

   // One run: kernel is ready except for a hold window on beat hold_beat; returns the response
   // word once all 16 input beats are in. abort_after >= 0 returns as soon as that many beats are seen.
   task automatic do_run(input logic [15:0] base, input logic [3:0] ss, input logic [3:0] ks,
                         input int hold_beat, input int hold_len, input int abort_after,
                         input logic [15:0] resp,
                         output int idle_cnt, output int done_cnt, output int span);
      int beats, held, cyc, first_hs, last_hs;
      bit resp_taken, fin, snk_chk, holding;
      logic [15:0] b;
      beats = 0; held = 0; cyc = 0; first_hs = 0; last_hs = 0;
      resp_taken = 0; fin = 0; snk_chk = 0;
      idle_cnt = 0; done_cnt = 0;
      for (int k = 0; k < 16; k++) begin
         b = base + 16'(k);
         exp_q.push_back(b);
      end
      @(negedge ap_clk);
      data_base = base;
      src_stall = ss;
      snk_stall = ks;
      start = 1'b1;
      @(negedge ap_clk);
      start = 1'b0;
      while (!fin && cyc < 3000) begin
         holding = k_if.in_r_TVALID && beats == hold_beat && held < hold_len;
         k_if.in_r_TREADY = !holding;
         if (holding) held++;
         k_if.out_r_TVALID = (beats == 16) && !resp_taken;
         k_if.out_r_TDATA = resp;
         #1;
         if (holding) begin
            b = base + 16'(hold_beat);
            check("hold_tdata", k_if.in_r_TDATA, b);
            check("hold_tlast", k_if.in_r_TLAST, 0);
            check("hold_src_blk", src_blk, 1);
         end
         if (ks == 0 && beats == 4 && !snk_chk) begin
            check("snk_blk_idle_sink", snk_blk, 1);
            snk_chk = 1;
         end
         if (busy && !k_if.in_r_TVALID && beats < 16) idle_cnt++;
         if (k_if.in_r_TVALID && k_if.in_r_TREADY) begin
            if (exp_q.size() == 0) begin
               check("sb_extra_beat", 1, 0);
            end else begin
               b = exp_q.pop_front();
               check("beat_data", k_if.in_r_TDATA, b);
            end
            check("beat_tlast", k_if.in_r_TLAST, (beats == 15) ? 1 : 0);
            if (beats == 0) first_hs = cyc;
            last_hs = cyc;
            beats++;
         end
         if (k_if.out_r_TVALID && k_if.out_r_TREADY) resp_taken = 1;
         if (done) done_cnt++;
         else if (done_cnt > 0) fin = 1;
         if (abort_after >= 0 && beats == abort_after) fin = 1;
         if (!fin) begin
            @(negedge ap_clk);
            cyc++;
         end
      end
      check("run_finished", fin, 1);
      k_if.out_r_TVALID = 1'b0;
      span = last_hs - first_hs;
   endtask

   initial begin
      int idle, dcnt, span, run_cnt, cyc;
      ap_rst = 1'b1;
      start = 1'b0;
      src_stall = 4'd0;
      snk_stall = 4'd0;
      data_base = '0;
      k_if.in_r_TREADY = 1'b0;
      k_if.out_r_TVALID = 1'b0;
      k_if.out_r_TDATA = '0;
      do_reset();

      // Full throughput
      do_run(16'h0100, 4'd0, 4'd0, -1, 0, -1, 16'h1234, idle, dcnt, span);
      check("full_span", span, 15);
      check("full_idle", idle, 1);
      check("full_done_cnt", dcnt, 1);
      check("full_sb_empty", exp_q.size(), 0);
      check("full_last_out", last_out, 16'h1234);
      check("full_no_hang", stall_detect, 0);
      check("full_idle_state", fsm_state, 0);

      // Data wrap
      do_run(16'hFFFE, 4'd0, 4'd0, -1, 0, -1, 16'hBEEF, idle, dcnt, span);
      check("wrap_done_cnt", dcnt, 1);
      check("wrap_sb_empty", exp_q.size(), 0);
      check("wrap_last_out", last_out, 16'hBEEF);

      // Backpressure on beat 3 for 5 cycles
      do_run(16'h3000, 4'd0, 4'd0, 3, 5, -1, 16'h0042, idle, dcnt, span);
      check("bp_span", span, 20);
      check("bp_done_cnt", dcnt, 1);
      check("bp_sb_empty", exp_q.size(), 0);
      check("bp_last_out", last_out, 16'h0042);

      // Beat 0 accepted exactly in the watchdog terminal-count cycle
      do_run(16'h4000, 4'd0, 4'd0, 0, 1022, -1, 16'h7777, idle, dcnt, span);
      check("wd_edge_no_hang", stall_detect, 0);
      check("wd_edge_done_cnt", dcnt, 1);
      check("wd_edge_sb_empty", exp_q.size(), 0);

      // Throttled source and sink
      do_run(16'h5000, 4'd8, 4'd8, -1, 0, -1, 16'h1111, idle, dcnt, span);
      check("thr_idle_range", (idle >= 4 && idle <= 40) ? 1 : 0, 1);
      check("thr_done_cnt", dcnt, 1);
      check("thr_sb_empty", exp_q.size(), 0);
      check("thr_last_out", last_out, 16'h1111);
      check("thr_no_hang", stall_detect, 0);

      // Reset after beat 7, then a clean rerun
      do_run(16'h6000, 4'd0, 4'd0, -1, 0, 8, 16'h2222, idle, dcnt, span);
      check("abort_done_cnt", dcnt, 0);
      exp_q.delete();
      do_reset();
      @(negedge ap_clk);
      #1;
      check("abort_no_done", done, 0);
      check("abort_idle", fsm_state, 0);
      do_run(16'h6000, 4'd0, 4'd0, -1, 0, -1, 16'h2222, idle, dcnt, span);
      check("rerun_span", span, 15);
      check("rerun_done_cnt", dcnt, 1);
      check("rerun_sb_empty", exp_q.size(), 0);
      check("rerun_last_out", last_out, 16'h2222);

      // Hang: kernel never accepts nor produces
      @(negedge ap_clk);
      data_base = 16'h0200;
      src_stall = 4'd0;
      snk_stall = 4'd0;
      k_if.in_r_TREADY = 1'b0;
      k_if.out_r_TVALID = 1'b0;
      start = 1'b1;
      @(negedge ap_clk);
      start = 1'b0;
      run_cnt = 0;
      cyc = 0;
      #1;
      while (!stall_detect && cyc < 1200) begin
         if (busy) run_cnt++;
         @(negedge ap_clk);
         #1;
         cyc++;
      end
      check("hang_detected", stall_detect, 1);
      check("hang_run_cycles", run_cnt, 1024);
      check("hang_state", fsm_state, 3);
      check("hang_busy", busy, 0);
`ifdef STALL_TRACE_EN
      check("hang_stall_cycle", stall_cycle, 1024);
`else
      check("hang_stall_cycle", stall_cycle, 0);
`endif
      @(negedge ap_clk);
      #1;
      check("hang_tvalid_off", k_if.in_r_TVALID, 0);
      check("hang_tready_off", k_if.out_r_TREADY, 0);
      start = 1'b1;
      repeat (3) @(negedge ap_clk);
      #1;
      start = 1'b0;
      check("hang_start_ignored", fsm_state, 3);
      check("hang_no_done", done, 0);
      check("hang_sticky", stall_detect, 1);
      do_reset();
      check("hang_cleared_by_rst", stall_detect, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/axis_stall_driver.md
Name: axis_stall_driver

Overview:
- Synthesizable AXI-Stream traffic endpoint for the kernel under test.
- Acts as the source on the kernel's `in_r` stream and as the sink on its `out_r` stream.
- Applies programmable pseudo-random throttling, so both blocking directions can be provoked on purpose.
- A no-progress watchdog flags a hung kernel. It is the active counterpart to the passive deadlock monitors in the simulation top.

Parameters:
DATA_W, 16, TDATA width of both streams
IN_WORDS, 16, beats sent on in_r per run (>=1)
OUT_WORDS, 1, beats accepted on out_r per run (>=1)
TIMEOUT, 1024, consecutive handshake-free RUN cycles before hang is declared (>=2)
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous reset, active-high
start  in  1  run request, sampled in IDLE only
src_stall  in  4  source throttle level, 0 = never stall
snk_stall  in  4  sink throttle level, 0 = never stall
data_base  in  DATA_W  value of first source beat
in_r_TDATA  out  DATA_W  source data
in_r_TVALID  out  1  source valid
in_r_TLAST  out  1  high on final source beat
in_r_TREADY  in  1  kernel ready
out_r_TDATA  in  DATA_W  kernel result data
out_r_TVALID  in  1  kernel result valid
out_r_TREADY  out  1  sink ready
busy  out  1  FSM in RUN
done  out  1  one-cycle pulse on run completion
last_out  out  DATA_W  most recently accepted out_r word
stall_detect  out  1  sticky hang flag
src_blk  out  1  in_r_TVALID & ~in_r_TREADY
snk_blk  out  1  out_r_TREADY & ~out_r_TVALID
stall_cycle  out  32  RUN cycle index at which hang declared

Behaviour:
- **Reset values:** All outputs are 0 after ap_rst, except that the LFSR is loaded with LFSR_SEED. ap_rst mid-run aborts immediately; no TLAST and no done pulse are emitted.
- **FSM states:** IDLE, RUN, DONE, HUNG.
  - IDLE -> RUN when start=1. On entry, clear the sent/received counters, the watchdog and the cycle counter.
  - RUN -> DONE when sent==IN_WORDS and rcvd==OUT_WORDS (this includes the cycle of the final handshake).
  - DONE -> IDLE after exactly 1 cycle. done=1 only in DONE.
  - RUN -> HUNG when the watchdog fires. HUNG is held until ap_rst; start is ignored.
  - start is ignored outside IDLE.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in RUN, holds otherwise.
  - src_ok = lfsr[3:0] >= src_stall.
  - snk_ok = lfsr[7:4] >= snk_stall.
- **Source:**
  - Beat k (0-based) carries data_base+k, modulo 2^DATA_W (wrap, no saturation).
  - in_r_TLAST=1 only on beat IN_WORDS-1.
  - Registered TVALID. In any RUN cycle where TVALID=0, or a handshake occurs, next TVALID = (beats remaining after this cycle > 0) & src_ok.
  - While TVALID=1 and TREADY=0, TDATA, TLAST and TVALID hold stable (AXI rule). This gives full throughput at src_stall=0.
- **Sink:**
  - Registered out_r_TREADY = RUN & (rcvd after this cycle < OUT_WORDS) & snk_ok.
  - On handshake, increment rcvd and update last_out.
  - Beats beyond OUT_WORDS are never accepted (TREADY stays 0).
- **Watchdog:**
  - Counter is cleared on any in_r or out_r handshake and in non-RUN states.
  - Otherwise it increments each RUN cycle.
  - When it reaches TIMEOUT, stall_detect=1 on the next cycle, stall_cycle = RUN cycle index, and the FSM goes to HUNG.
  - A handshake on the same cycle as the terminal count wins: the counter clears and no hang is declared.
  - stall_detect is cleared by ap_rst only.
  - In HUNG, in_r_TVALID and out_r_TREADY are both forced to 0 on the next cycle.
- src_blk and snk_blk are combinational and valid in every state.

Optional Feature:
STALL_TRACE_EN
- Defined: the 32-bit RUN cycle counter is implemented and drives stall_cycle. Simulation additionally prints one `$display` line with cycle, sent and rcvd at the HUNG transition.
- Undefined: no cycle counter; stall_cycle is tied to 0; no display. All other behaviour is identical.

Test Plan:
- **Full throughput:** src_stall=0, snk_stall=0, data_base=0x0100, kernel TREADY=1, kernel returns 0x1234 after the last input -> 16 beats on 16 consecutive cycles 0x0100..0x010F; TLAST only on 0x010F; last_out=0x1234; done pulses once; stall_detect=0.
- **Data wrap:** data_base=0xFFFE, IN_WORDS=16 -> beats 0xFFFE, 0xFFFF, 0x0000 ... 0x000D.
- **Backpressure hold:** kernel holds TREADY=0 for 5 cycles with TVALID=1 on beat 3 -> TDATA=base+3 and TLAST=0 stable; src_blk=1 for those 5 cycles; beat 4 is not skipped.
- **Hang detection:** kernel never asserts TREADY or out TVALID, TIMEOUT=1024 -> stall_detect=1 after 1024 handshake-free RUN cycles; FSM in HUNG; TVALID=0 next cycle; start ignored; with STALL_TRACE_EN, stall_cycle=1024 ±1 per the defined index.
- **Throttling:** src_stall=8, snk_stall=8 with an always-ready kernel -> all 16 beats delivered in order; done asserted; TVALID idle-cycle count in [4, 40]; no hang.
- **Reset mid-run:** ap_rst after beat 7 -> all outputs 0 the next cycle; no done pulse; a new start runs a complete 16-beat sequence from data_base.
